multi_lane_pkt_arb: RTL and testbench
=====================================

// Module: multi_lane_pkt_arb
// PURPOSE
//  N-lane successor to the dual-buffer receive path. Collects completed packets from
//  NUM_LANES shift-buffer/sync lanes into per-lane pending slots. Forwards them one at a
//  time via round-robin arbitration, using an output valid/ready handshake.
//  Optional duplicate suppression, plus saturating drop/dup counters. Sits between the
//  lane shift buffers and the packet decoder.
// PARAMETERS
//  NUM_LANES  2   number of input lanes (>=1)
//  PKT_W      64  packet width in bits
//  DEDUP      1   1: drop pending packets identical to the granted one; 0: forward all
//  CNT_W      8   width of drop_cnt / dup_cnt
// PORTS
//  clk           in   1                clock
//  rst           in   1                reset, synchronous, active-high
//  lane_pkt_rec  in   NUM_LANES        per-lane 1-cycle "packet complete" strobe
//  lane_dout     in   NUM_LANES*PKT_W  lane i packet = lane_dout[i*PKT_W +: PKT_W]
//  pkt_ready     in   1                downstream accepts dout this cycle
//  pkt_rec       out  1                dout valid
//  dout          out  PKT_W            forwarded packet
//  src_lane      out  LIDX_W           lane index of dout; LIDX_W = max(1,$clog2(NUM_LANES))
//  drop_cnt      out  CNT_W            packets lost to a full pending slot (saturating)
//  dup_cnt       out  CNT_W            packets removed by DEDUP (saturating)
// BEHAVIOUR
//  Reset: all outputs 0, pend_vld all 0, rr pointer 0. Reset mid-packet discards everything.
//  Capture:
//   - lane_pkt_rec[i] at edge k loads pend_data[i] <= lane slice and sets pend_vld[i].
//   - Slot full and not granted at edge k: new packet dropped, old one kept, drop_cnt+1.
//   - Slot granted at edge k while strobe also present: new packet captured, no drop.
//  Output load (fire) when pend_vld != 0 and (!pkt_rec | pkt_ready):
//   - Winner is the first set pend_vld at or after ptr, searched upward with wrap.
//   - dout <= pend_data[g], src_lane <= g, pkt_rec <= 1, pend_vld[g] cleared,
//     ptr <= (g+1) mod NUM_LANES.
//  No fire and pkt_ready=1: pkt_rec <= 0, dout and src_lane hold.
//  pkt_rec=1 and pkt_ready=0: dout, src_lane and pkt_rec hold stable.
//  Latency: strobe at edge k gives pkt_rec=1 after edge k+1 (output free). No bypass.
//  Throughput: 1 packet/cycle while pkt_ready=1.
//  DEDUP=1: on fire, every other lane j with pend_vld[j] & pend_data[j]==pend_data[g]
//   is cleared at the same edge; dup_cnt += count of such j.
//   Same-edge captures are not compared.
//  Counters: saturate at all-ones, never wrap; multiple drops in one cycle add their count.
//  NUM_LANES=1: arbiter degenerates, src_lane = 0, ptr stays 0.
// STRUCTURE
//  pkt_arb_defs.vh: default PKT_W, LIDX_W macro, CNT saturation-add helper function.
//  Sub-module rr_arbiter #(N): in req[N], ptr[LIDX_W]; out gnt_onehot[N], gnt_idx,
//   gnt_any. Purely combinational.
//  Top holds pend regs, output reg, ptr, dedup comparators (N-1 PKT_W-bit compares), counters.
// TESTING
//  1 single lane0 strobe, data 64'hA5A5_0000_0000_0001, ready=1
//    -> pkt_rec=1 two edges later, src_lane=0, one cycle wide.
//  2 lanes 0,1 strobe same cycle, distinct data, ready=1
//    -> lane0 then lane1 on consecutive cycles; next collision starts at lane1 then lane0.
//  3 DEDUP=1, lanes 0,1 same data 64'hDEAD_BEEF
//    -> exactly one output, dup_cnt=1; DEDUP=0 -> two outputs, dup_cnt=0.
//  4 ready=0 held 5 cycles, lane0 strobed 3 times
//    -> dout stable at first packet, second held pending, drop_cnt=1 (third dropped).
//  5 drop_cnt driven past 255 (CNT_W=8) -> sticks at 8'hFF.
//  6 rst asserted while pkt_rec=1 and slots pending
//    -> next cycle all outputs 0, no stale packet after release.

Source files
------------

// File: rtl/multi_lane_pkt_arb_pkg.sv
// Shared defaults and helpers for the multi-lane packet arbiter.
// Counter widths are assumed to be at most 32 bits.
package multi_lane_pkt_arb_pkg;

  localparam int DEF_NUM_LANES = 2;
  localparam int DEF_PKT_W     = 64;
  localparam int DEF_CNT_W     = 8;

  // Index width never collapses to zero, so a single-lane build still has a src_lane bit.
  function automatic int lidx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int w);
    logic [63:0] maxv;
    logic [63:0] sum;
    maxv = (64'd1 << w) - 64'd1;
    sum  = a + b;
    return (sum > maxv) ? maxv : sum;
  endfunction

endpackage

// File: rtl/multi_lane_pkt_arb_if.sv
// Lane-side inputs and decoder-side outputs of the packet arbiter.
// The master drives the lanes and the ready signal; the slave is the arbiter.
interface multi_lane_pkt_arb_if
  import multi_lane_pkt_arb_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int PKT_W     = DEF_PKT_W,
  parameter int CNT_W     = DEF_CNT_W
);
  localparam int LIDX_W = lidx_width(NUM_LANES);

  logic [NUM_LANES-1:0]       lane_pkt_rec;
  logic [NUM_LANES*PKT_W-1:0] lane_dout;
  logic                       pkt_ready;
  logic                       pkt_rec;
  logic [PKT_W-1:0]           dout;
  logic [LIDX_W-1:0]          src_lane;
  logic [CNT_W-1:0]           drop_cnt;
  logic [CNT_W-1:0]           dup_cnt;

  modport master (
    output lane_pkt_rec, lane_dout, pkt_ready,
    input  pkt_rec, dout, src_lane, drop_cnt, dup_cnt
  );

  modport slave (
    input  lane_pkt_rec, lane_dout, pkt_ready,
    output pkt_rec, dout, src_lane, drop_cnt, dup_cnt
  );
endinterface

// File: rtl/multi_lane_pkt_arb_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or above i_ptr,
// wrapping around to lane 0.
module rr_arbiter
  import multi_lane_pkt_arb_pkg::*;
#(
  parameter int N      = DEF_NUM_LANES,
  parameter int LIDX_W = lidx_width(N)
) (
  input  logic [N-1:0]      i_req,
  input  logic [LIDX_W-1:0] i_ptr,
  output logic [N-1:0]      o_gnt_onehot,
  output logic [LIDX_W-1:0] o_gnt_idx,
  output logic              o_gnt_any
);

  logic [LIDX_W-1:0] w_idx;

  always_comb begin
    o_gnt_onehot = '0;
    o_gnt_idx    = '0;
    o_gnt_any    = 1'b0;
    w_idx        = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = LIDX_W'((int'(i_ptr) + i) % N);
      if (!o_gnt_any && i_req[w_idx]) begin
        o_gnt_any           = 1'b1;
        o_gnt_idx           = w_idx;
        o_gnt_onehot[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_lane_pkt_arb.sv
// Collects completed lane packets into per-lane pending slots and forwards them one at a
// time over a valid/ready output, with optional duplicate suppression and saturating counters.
module multi_lane_pkt_arb
  import multi_lane_pkt_arb_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int PKT_W     = DEF_PKT_W,
  parameter int DEDUP     = 1,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  multi_lane_pkt_arb_if.slave     io_arb
);

  localparam int LIDX_W = lidx_width(NUM_LANES);

  logic [NUM_LANES-1:0] r_pend_vld;
  logic [PKT_W-1:0]     r_pend_data [NUM_LANES];
  logic                 r_pkt_rec;
  logic [PKT_W-1:0]     r_dout;
  logic [LIDX_W-1:0]    r_src_lane;
  logic [LIDX_W-1:0]    r_ptr;
  logic [CNT_W-1:0]     r_drop_cnt;
  logic [CNT_W-1:0]     r_dup_cnt;

  logic [NUM_LANES-1:0] w_gnt_onehot;
  logic [LIDX_W-1:0]    w_gnt_idx;
  logic                 w_gnt_any;
  logic                 w_fire;
  logic [PKT_W-1:0]     w_gnt_data;
  logic [NUM_LANES-1:0] w_dup_mask;
  logic [NUM_LANES-1:0] w_clear;
  logic [NUM_LANES-1:0] w_drop_mask;
  logic [31:0]          w_drop_inc;
  logic [31:0]          w_dup_inc;
  logic [LIDX_W-1:0]    w_ptr_next;

  rr_arbiter #(.N(NUM_LANES), .LIDX_W(LIDX_W)) u_rr_arbiter (
    .i_req        (r_pend_vld),
    .i_ptr        (r_ptr),
    .o_gnt_onehot (w_gnt_onehot),
    .o_gnt_idx    (w_gnt_idx),
    .o_gnt_any    (w_gnt_any)
  );

  assign w_fire      = w_gnt_any & (~r_pkt_rec | io_arb.pkt_ready);
  assign w_gnt_data  = r_pend_data[w_gnt_idx];
  assign w_clear     = ({NUM_LANES{w_fire}} & w_gnt_onehot) | w_dup_mask;
  // A slot being emptied this edge (granted or deduplicated) accepts a new packet instead of dropping it.
  assign w_drop_mask = io_arb.lane_pkt_rec & r_pend_vld & ~w_clear;

  always_comb begin
    w_dup_mask = '0;
    w_drop_inc = '0;
    w_dup_inc  = '0;
    for (int j = 0; j < NUM_LANES; j++) begin
      if (DEDUP != 0 && w_fire && !w_gnt_onehot[j] && r_pend_vld[j] &&
          r_pend_data[j] == w_gnt_data) begin
        w_dup_mask[j] = 1'b1;
      end
      w_drop_inc = w_drop_inc + 32'(w_drop_mask[j]);
      w_dup_inc  = w_dup_inc + 32'(w_dup_mask[j]);
    end
  end

  always_comb begin
    if (int'(w_gnt_idx) >= NUM_LANES - 1) begin
      w_ptr_next = '0;
    end else begin
      w_ptr_next = w_gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_vld <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (io_arb.lane_pkt_rec[i] && (!r_pend_vld[i] || w_clear[i])) begin
          r_pend_data[i] <= io_arb.lane_dout[i*PKT_W +: PKT_W];
          r_pend_vld[i]  <= 1'b1;
        end else if (w_clear[i]) begin
          r_pend_vld[i]  <= 1'b0;
        end
      end
    end
  end

  // A held output (valid without ready) stays frozen until the decoder takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_rec  <= 1'b0;
      r_dout     <= '0;
      r_src_lane <= '0;
      r_ptr      <= '0;
    end else if (w_fire) begin
      r_pkt_rec  <= 1'b1;
      r_dout     <= w_gnt_data;
      r_src_lane <= w_gnt_idx;
      r_ptr      <= w_ptr_next;
    end else if (io_arb.pkt_ready) begin
      r_pkt_rec  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
      r_dup_cnt  <= '0;
    end else begin
      r_drop_cnt <= CNT_W'(sat_add(64'(r_drop_cnt), 64'(w_drop_inc), CNT_W));
      r_dup_cnt  <= CNT_W'(sat_add(64'(r_dup_cnt), 64'(w_dup_inc), CNT_W));
    end
  end

  assign io_arb.pkt_rec  = r_pkt_rec;
  assign io_arb.dout     = r_dout;
  assign io_arb.src_lane = r_src_lane;
  assign io_arb.drop_cnt = r_drop_cnt;
  assign io_arb.dup_cnt  = r_dup_cnt;

endmodule

// File: tb/tb_multi_lane_pkt_arb.sv
// Directed bench for multi_lane_pkt_arb: a dedup-enabled and a dedup-disabled instance share
// the same lane stimulus; outputs are sampled on the falling edge.
module tb_multi_lane_pkt_arb;
  import multi_lane_pkt_arb_pkg::*;

  typedef struct {
    logic [1:0]  strobe;
    logic [63:0] d0;
    logic [63:0] d1;
    logic        ready;
    logic        expRec;
    logic [63:0] expDout;
    logic        expSrc;
    logic [7:0]  expDrop;
    logic [7:0]  expDup;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  vec_t vecs [23];

  multi_lane_pkt_arb_if #(.NUM_LANES(2), .PKT_W(64), .CNT_W(8)) busA ();
  multi_lane_pkt_arb_if #(.NUM_LANES(2), .PKT_W(64), .CNT_W(8)) busB ();

  assign busB.lane_pkt_rec = busA.lane_pkt_rec;
  assign busB.lane_dout    = busA.lane_dout;
  assign busB.pkt_ready    = busA.pkt_ready;

  multi_lane_pkt_arb #(.NUM_LANES(2), .PKT_W(64), .DEDUP(1), .CNT_W(8)) dutA (
    .clk (clk), .rst (rst), .io_arb (busA)
  );

  multi_lane_pkt_arb #(.NUM_LANES(2), .PKT_W(64), .DEDUP(0), .CNT_W(8)) dutB (
    .clk (clk), .rst (rst), .io_arb (busB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs; returns on the next falling edge, after one rising edge.
  task automatic applyStimulus(input logic [1:0] strobe, input logic [63:0] d0,
                               input logic [63:0] d1, input logic ready);
    busA.lane_pkt_rec = strobe;
    busA.lane_dout    = {d1, d0};
    busA.pkt_ready    = ready;
    @(negedge clk);
  endtask

  task automatic checkDut(input string tag, input bit useB, input logic expRec,
                          input logic [63:0] expDout, input logic expSrc,
                          input logic [7:0] expDrop, input logic [7:0] expDup);
    logic        rec;
    logic [63:0] dout;
    logic        src;
    logic [7:0]  drop;
    logic [7:0]  dup;
    rec  = useB ? busB.pkt_rec  : busA.pkt_rec;
    dout = useB ? busB.dout     : busA.dout;
    src  = useB ? busB.src_lane : busA.src_lane;
    drop = useB ? busB.drop_cnt : busA.drop_cnt;
    dup  = useB ? busB.dup_cnt  : busA.dup_cnt;
    checkOutput({tag, ".pkt_rec"},  64'(rec),  64'(expRec));
    checkOutput({tag, ".dout"},     dout,      expDout);
    checkOutput({tag, ".src_lane"}, 64'(src),  64'(expSrc));
    checkOutput({tag, ".drop_cnt"}, 64'(drop), 64'(expDrop));
    checkOutput({tag, ".dup_cnt"},  64'(dup),  64'(expDup));
  endtask

  task automatic resetBoth();
    rst = 1'b1;
    applyStimulus(2'b00, 64'h0, 64'h0, 1'b1);
    applyStimulus(2'b00, 64'h0, 64'h0, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    busA.lane_pkt_rec = 2'b00;
    busA.lane_dout    = '0;
    busA.pkt_ready    = 1'b1;

    // strobe d0 d1 ready | rec dout src drop dup (dedup instance)
    vecs[0]  = '{2'b11, 64'h1111, 64'h2222, 1'b1, 1'b0, 64'h0,    1'b0, 8'd0, 8'd0};
    vecs[1]  = '{2'b00, 64'h0,    64'h0,    1'b1, 1'b1, 64'h1111, 1'b0, 8'd0, 8'd0};
    vecs[2]  = '{2'b00, 64'h0,    64'h0,    1'b1, 1'b1, 64'h2222, 1'b1, 8'd0, 8'd0};
    vecs[3]  = '{2'b00, 64'h0,    64'h0,    1'b1, 1'b0, 64'h2222, 1'b1, 8'd0, 8'd0};
    vecs[4]  = '{2'b01, 64'h3333, 64'h0,    1'b1, 1'b0, 64'h2222, 1'b1, 8'd0, 8'd0};
    vecs[5]  = '{2'b11, 64'h4444, 64'h5555, 1'b1, 1'b1, 64'h3333, 1'b0, 8'd0, 8'd0};
    vecs[6]  = '{2'b00, 64'h0,    64'h0,    1'b1, 1'b1, 64'h5555, 1'b1, 8'd0, 8'd0};
    vecs[7]  = '{2'b00, 64'h0,    64'h0,    1'b1, 1'b1, 64'h4444, 1'b0, 8'd0, 8'd0};
    vecs[8]  = '{2'b00, 64'h0,    64'h0,    1'b1, 1'b0, 64'h4444, 1'b0, 8'd0, 8'd0};
    vecs[9]  = '{2'b01, 64'hA5A5_0000_0000_0001, 64'h0, 1'b1, 1'b0, 64'h4444, 1'b0, 8'd0, 8'd0};
    vecs[10] = '{2'b00, 64'h0, 64'h0, 1'b1, 1'b1, 64'hA5A5_0000_0000_0001, 1'b0, 8'd0, 8'd0};
    vecs[11] = '{2'b00, 64'h0, 64'h0, 1'b1, 1'b0, 64'hA5A5_0000_0000_0001, 1'b0, 8'd0, 8'd0};
    vecs[12] = '{2'b11, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b1, 1'b0, 64'hA5A5_0000_0000_0001, 1'b0, 8'd0, 8'd0};
    vecs[13] = '{2'b00, 64'h0,    64'h0,    1'b1, 1'b1, 64'hDEAD_BEEF, 1'b1, 8'd0, 8'd1};
    vecs[14] = '{2'b00, 64'h0,    64'h0,    1'b1, 1'b0, 64'hDEAD_BEEF, 1'b1, 8'd0, 8'd1};
    vecs[15] = '{2'b01, 64'h0AAA, 64'h0,    1'b0, 1'b0, 64'hDEAD_BEEF, 1'b1, 8'd0, 8'd1};
    vecs[16] = '{2'b00, 64'h0,    64'h0,    1'b0, 1'b1, 64'h0AAA, 1'b0, 8'd0, 8'd1};
    vecs[17] = '{2'b01, 64'h0BBB, 64'h0,    1'b0, 1'b1, 64'h0AAA, 1'b0, 8'd0, 8'd1};
    vecs[18] = '{2'b01, 64'h0CCC, 64'h0,    1'b0, 1'b1, 64'h0AAA, 1'b0, 8'd1, 8'd1};
    vecs[19] = '{2'b00, 64'h0,    64'h0,    1'b0, 1'b1, 64'h0AAA, 1'b0, 8'd1, 8'd1};
    vecs[20] = '{2'b00, 64'h0,    64'h0,    1'b0, 1'b1, 64'h0AAA, 1'b0, 8'd1, 8'd1};
    vecs[21] = '{2'b00, 64'h0,    64'h0,    1'b1, 1'b1, 64'h0BBB, 1'b0, 8'd1, 8'd1};
    vecs[22] = '{2'b00, 64'h0,    64'h0,    1'b1, 1'b0, 64'h0BBB, 1'b0, 8'd1, 8'd1};

    applyStimulus(2'b00, 64'h0, 64'h0, 1'b1);
    applyStimulus(2'b00, 64'h0, 64'h0, 1'b1);
    checkDut("reset.A", 1'b0, 1'b0, 64'h0, 1'b0, 8'd0, 8'd0);
    checkDut("reset.B", 1'b1, 1'b0, 64'h0, 1'b0, 8'd0, 8'd0);
    rst = 1'b0;

    for (int v = 0; v < 23; v++) begin
      applyStimulus(vecs[v].strobe, vecs[v].d0, vecs[v].d1, vecs[v].ready);
      checkDut($sformatf("vec%0d", v), 1'b0, vecs[v].expRec, vecs[v].expDout,
               vecs[v].expSrc, vecs[v].expDrop, vecs[v].expDup);
    end

    // Identical data on both lanes: dedup instance emits once, plain instance twice.
    resetBoth();
    applyStimulus(2'b11, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b1);
    checkDut("dup0.A", 1'b0, 1'b0, 64'h0, 1'b0, 8'd0, 8'd0);
    checkDut("dup0.B", 1'b1, 1'b0, 64'h0, 1'b0, 8'd0, 8'd0);
    applyStimulus(2'b00, 64'h0, 64'h0, 1'b1);
    checkDut("dup1.A", 1'b0, 1'b1, 64'hDEAD_BEEF, 1'b0, 8'd0, 8'd1);
    checkDut("dup1.B", 1'b1, 1'b1, 64'hDEAD_BEEF, 1'b0, 8'd0, 8'd0);
    applyStimulus(2'b00, 64'h0, 64'h0, 1'b1);
    checkDut("dup2.A", 1'b0, 1'b0, 64'hDEAD_BEEF, 1'b0, 8'd0, 8'd1);
    checkDut("dup2.B", 1'b1, 1'b1, 64'hDEAD_BEEF, 1'b1, 8'd0, 8'd0);
    applyStimulus(2'b00, 64'h0, 64'h0, 1'b1);
    checkDut("dup3.B", 1'b1, 1'b0, 64'hDEAD_BEEF, 1'b1, 8'd0, 8'd0);

    // Stalled output with both lanes strobing every cycle: 1 drop at edge 2, then 2 per edge.
    resetBoth();
    for (int n = 0; n < 10; n++) applyStimulus(2'b11, 64'h1, 64'h2, 1'b0);
    checkDut("sat10.A", 1'b0, 1'b1, 64'h1, 1'b0, 8'd17, 8'd0);
    checkDut("sat10.B", 1'b1, 1'b1, 64'h1, 1'b0, 8'd17, 8'd0);
    for (int n = 0; n < 150; n++) applyStimulus(2'b11, 64'h1, 64'h2, 1'b0);
    checkDut("satEnd.A", 1'b0, 1'b1, 64'h1, 1'b0, 8'hFF, 8'd0);
    checkDut("satEnd.B", 1'b1, 1'b1, 64'h1, 1'b0, 8'hFF, 8'd0);

    // Reset while a packet is presented and both slots are full.
    rst = 1'b1;
    applyStimulus(2'b00, 64'h0, 64'h0, 1'b0);
    checkDut("midRst.A", 1'b0, 1'b0, 64'h0, 1'b0, 8'd0, 8'd0);
    checkDut("midRst.B", 1'b1, 1'b0, 64'h0, 1'b0, 8'd0, 8'd0);
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      applyStimulus(2'b00, 64'h0, 64'h0, 1'b1);
      checkDut($sformatf("postRst%0d.A", n), 1'b0, 1'b0, 64'h0, 1'b0, 8'd0, 8'd0);
    end
    checkDut("postRst.B", 1'b1, 1'b0, 64'h0, 1'b0, 8'd0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
